time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
Front-panel controller that writes the time-set interface of the 12-hour BCD time counter. It snapshots the running time, lets the user edit the hour, minute and second fields with pulse buttons, then drives the load handshake so the counter adopts the edited value. It drives the counter's state[1:0] and timeset[18:0] inputs and reads its present_time[18:0] output.

Parameters:
COMMIT_CYCLES, 1, number of clk cycles state is held at 2'b01. Must be at least 1 and at least the clk-to-counter-clock ratio, so the counter sees one load edge.

Ports:
clk  input  1  system clock; the single clock for this block
rst  input  1  asynchronous, active-high reset
btn_mode  input  1  single-cycle pulse, debounced upstream; RUN->EDIT, or EDIT->COMMIT
btn_next  input  1  single-cycle pulse; advance the selected field
btn_inc  input  1  single-cycle pulse; increment the selected field
btn_dec  input  1  single-cycle pulse; decrement the selected field
present_time  input  19  running time from the counter. Packing: [18] hour10, [17:14] hour, [13:11] min10, [10:7] min, [6:4] sec10, [3:0] sec
state  output  2  counter command: 00 = run, 01 = load timeset, 10 = hold (counter freezes)
timeset  output  19  edited time, same packing as present_time
field_sel  output  2  selected field: 10 = hour, 01 = minute, 00 = second; 11 is never driven
editing  output  1  high while in EDIT

Behaviour:
- All outputs are registered.
- Reset (async, immediate, not clock-gated):
  - state=00, timeset=0, field_sel=10, editing=0.
  - Commit counter is cleared; FSM goes to RUN.
  - Reset asserted mid-EDIT or mid-COMMIT discards any edit.
- FSM states and transitions:
  - RUN (state=00): btn_mode at edge n -> from n+1, EDIT, timeset=present_time sampled at edge n, field_sel=10, editing=1. btn_next, btn_inc and btn_dec are ignored.
  - EDIT (state=10): btn_mode -> COMMIT at the next edge; a simultaneous next, inc or dec is ignored. Otherwise:
    - btn_next rotates field_sel 10->01->00->10.
    - If next and inc/dec arrive together, next wins and no arithmetic is done.
    - btn_inc or btn_dec updates only the selected field; the result is visible at the next edge.
    - inc and dec together: no change.
  - COMMIT (state=01): held for exactly COMMIT_CYCLES cycles; timeset stable; editing=0; all buttons ignored. Then RUN.
- Field arithmetic (BCD, each field independent, never carries or borrows into a neighbour):
  - Seconds: 00..59. Inc 59->00; dec 00->59. Units 9->0 increments tens; units 0->9 decrements tens.
  - Minutes: same as seconds.
  - Hours: 00..11, encoded {hour10, hour}. Inc 09->10, 11->00. Dec 10->09, 00->11.
- Invalid snapshot (a BCD digit out of range, or hour >11): the first inc/dec on that field loads 00 for that field. Other fields keep their value.
- timeset holds its last value in RUN. This is harmless, because the counter only samples it while state=01.
- The bench may drive button inputs high for several cycles; each high cycle counts as one press.

Test Plan:
1. Assert rst asynchronously mid-cycle -> state=00, timeset=0, field_sel=10, editing=0 immediately, before the next edge.
2. present_time=11:59:58 (0x?? fields 1,1,5,9,5,8), pulse btn_mode -> next cycle state=10, editing=1, timeset=11:59:58. Then pulse btn_inc -> hours wrap: timeset=00:59:58, minutes and seconds unchanged.
3. In EDIT:
   - btn_next, then btn_dec on minute 59 -> 58.
   - Dec to 00, dec again -> 59.
   - btn_next to seconds at 58: two btn_inc -> 59, then 00, with the minute field unchanged.
   - btn_next again -> field_sel=10.
4. With COMMIT_CYCLES=3, pulse btn_mode in EDIT -> state=01 for exactly 3 cycles, timeset constant, then state=00. btn_inc during COMMIT has no effect.
5. In EDIT, btn_inc and btn_dec in the same cycle -> timeset unchanged. btn_mode and btn_inc in the same cycle -> COMMIT, no increment. btn_next and btn_inc together -> field advances, no increment.
6. Hour decrement sweep from 00 -> 11, 10, 09, ..., 00, 11. Also a snapshot of hour=13 (invalid) -> first inc gives 00.

Source files
------------

// File: rtl/time_set_if.sv
`timescale 1ns/1ps
// Time-set bundle between the front-panel controller and the rest of the
// system: debounced button pulses and the running time coming in, counter
// command / edited time / UI status going out.
//   master : controller side (drives state, timeset, field_sel, editing)
//   slave  : panel + counter side (drives buttons and present_time)
interface time_set_if;
    logic        btn_mode;
    logic        btn_next;
    logic        btn_inc;
    logic        btn_dec;
    logic [18:0] present_time;
    logic [1:0]  state;
    logic [18:0] timeset;
    logic [1:0]  field_sel;
    logic        editing;

    modport master (
        input  btn_mode, btn_next, btn_inc, btn_dec, present_time,
        output state, timeset, field_sel, editing
    );

    modport slave (
        output btn_mode, btn_next, btn_inc, btn_dec, present_time,
        input  state, timeset, field_sel, editing
    );
endinterface

// File: rtl/time_set_ctrl.sv
`timescale 1ns/1ps
// Front-panel time-set controller for the 12-hour BCD time counter.
// Snapshots present_time, lets the user edit hour/minute/second with pulse
// buttons, then holds the counter in load (state=01) for COMMIT_CYCLES clocks.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - time_set_if.master: btn_mode/next/inc/dec, present_time in;
//          state, timeset, field_sel, editing out (all registered)
//
// Time packing: [18] hour10, [17:14] hour, [13:11] min10, [10:7] min,
//               [6:4] sec10, [3:0] sec
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | counter running (00); mode enters EDIT with a snapshot
// EDIT   | counter frozen (10); next/inc/dec edit timeset; mode commits
// COMMIT | counter loads timeset (01) for COMMIT_CYCLES clocks, then RUN
module time_set_ctrl #(
    parameter int COMMIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    time_set_if.master bus
);

    localparam int CW = (COMMIT_CYCLES > 2) ? $clog2(COMMIT_CYCLES) : 1;

    // Encodings double as the counter command, so state is the FSM register.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        COMMIT = 2'b01,
        EDIT   = 2'b10
    } fsm_t;

    fsm_t          fsm;
    logic [CW-1:0] commit_cnt;
    logic [18:0]   timeset_r;
    logic [1:0]    field_sel_r;
    logic          editing_r;

    // Minutes/seconds field {tens[2:0], units[3:0]}, 00..59, wraps in place.
    // An out-of-range value is replaced by 00 on the first step.
    function automatic logic [6:0] ms_step(input logic [6:0] f, input logic up);
        logic [2:0] t;
        logic [3:0] u;
        t = f[6:4];
        u = f[3:0];
        if (t > 3'd5 || u > 4'd9) begin
            return 7'd0;
        end
        if (up) begin
            if (u == 4'd9) begin
                u = 4'd0;
                t = (t == 3'd5) ? 3'd0 : t + 3'd1;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (u == 4'd0) begin
                u = 4'd9;
                t = (t == 3'd0) ? 3'd5 : t - 3'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    // Hour field {hour10, hour[3:0]}, 00..11, wraps in place.
    function automatic logic [4:0] hr_step(input logic [4:0] f, input logic up);
        logic       t;
        logic [3:0] u;
        logic       valid;
        t = f[4];
        u = f[3:0];
        valid = t ? (u <= 4'd1) : (u <= 4'd9);
        if (!valid) begin
            return 5'd0;
        end
        if (up) begin
            if (t && u == 4'd1) begin
                t = 1'b0;
                u = 4'd0;
            end else if (!t && u == 4'd9) begin
                t = 1'b1;
                u = 4'd0;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (t && u == 4'd0) begin
                t = 1'b0;
                u = 4'd9;
            end else if (!t && u == 4'd0) begin
                t = 1'b1;
                u = 4'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= RUN;
            commit_cnt  <= '0;
            timeset_r   <= '0;
            field_sel_r <= 2'b10;
            editing_r   <= 1'b0;
        end else begin
            case (fsm)
                RUN: begin
                    if (bus.btn_mode) begin
                        fsm         <= EDIT;
                        timeset_r   <= bus.present_time;
                        field_sel_r <= 2'b10;
                        editing_r   <= 1'b1;
                    end
                end
                EDIT: begin
                    if (bus.btn_mode) begin
                        fsm        <= COMMIT;
                        editing_r  <= 1'b0;
                        commit_cnt <= CW'(COMMIT_CYCLES - 1);
                    end else if (bus.btn_next) begin
                        case (field_sel_r)
                            2'b10:   field_sel_r <= 2'b01;
                            2'b01:   field_sel_r <= 2'b00;
                            default: field_sel_r <= 2'b10;
                        endcase
                    end else if (bus.btn_inc ^ bus.btn_dec) begin
                        // inc and dec together cancel; exactly one selects direction
                        case (field_sel_r)
                            2'b10:   timeset_r[18:14] <= hr_step(timeset_r[18:14], bus.btn_inc);
                            2'b01:   timeset_r[13:7]  <= ms_step(timeset_r[13:7], bus.btn_inc);
                            2'b00:   timeset_r[6:0]   <= ms_step(timeset_r[6:0], bus.btn_inc);
                            default: ;
                        endcase
                    end
                end
                COMMIT: begin
                    if (commit_cnt == '0) begin
                        fsm <= RUN;
                    end else begin
                        commit_cnt <= commit_cnt - CW'(1);
                    end
                end
                default: fsm <= RUN;
            endcase
        end
    end

    assign bus.state     = fsm;
    assign bus.timeset   = timeset_r;
    assign bus.field_sel = field_sel_r;
    assign bus.editing   = editing_r;

endmodule
